fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit RISC pipeline; the producer end of the IF/ID pipeline register.
- Holds the PC and issues word reads to instruction memory over a req/ready handshake.
- Delivers each instruction with its address and a valid flag to IF/ID.
- Honours stall from the hazard unit and redirect from branch resolution.

Parameters:
- ADDR_W, 16, PC/address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- inp_clk  in  1  single clock; all state changes on rising edge.
- inp_rst_n  in  1  asynchronous, active-low reset.
- out_mem_req  out  1  fetch request to instruction memory (combinational).
- out_mem_addr  out  ADDR_W  fetch address; always equals PC.
- inp_mem_ready  in  1  memory returns inp_mem_data this cycle; only meaningful when out_mem_req=1.
- inp_mem_data  in  INSTR_W  fetched instruction.
- inp_stall  in  1  IF/ID must hold; the current instruction is not consumed.
- inp_branch_taken  in  1  redirect request; single-cycle pulse.
- inp_branch_target  in  ADDR_W  redirect PC.
- out_instruction  out  INSTR_W  registered instruction to IF/ID.
- out_address  out  ADDR_W  registered address of out_instruction.
- out_valid  out  1  registered; 0 means bubble.

Behaviour:
- Reset (async, inp_rst_n=0):
  - pc=RESET_PC, state=S_BOOT.
  - out_valid=0, out_instruction=0, out_address=0.
  - out_mem_req=0 immediately, not at the next edge.
- Consumption: IF/ID takes the instruction at every rising edge where out_valid=1 and inp_stall=0.
- Edge priority, highest first: reset > branch > stall > memory handshake.
- S_BOOT:
  - out_mem_req=0.
  - Next edge goes to S_FETCH; a branch seen in this cycle loads pc=target.
- S_FETCH:
  - out_mem_req = !inp_branch_taken && !(inp_stall && out_valid).
  - On branch: pc<=target, out_valid<=0, stay in S_FETCH. Returned data in the same cycle is discarded.
  - Else if inp_stall && out_valid: go to S_STALL; outputs and pc hold.
  - Else if req && ready: out_instruction<=inp_mem_data, out_address<=pc, out_valid<=1, pc<=pc+1 (wraps). Next state is S_STALL if inp_stall, else S_FETCH.
  - Else (req && !ready): out_valid<=0 (bubble), pc holds.
- S_STALL:
  - out_mem_req=0; outputs and pc hold while inp_stall=1.
  - On branch: pc<=target, out_valid<=0, go to S_FETCH.
  - When inp_stall=0: the instruction is consumed at that edge; out_valid<=0, go to S_FETCH.
  - One-cycle bubble after a stall is accepted by design.
- Latency:
  - First request is asserted 1 cycle after reset release.
  - With zero-wait memory, data is registered at the end of the request cycle.
  - Steady-state throughput is 1 instruction/cycle.
- out_mem_addr equals pc in every state; it is only qualified by out_mem_req.
- Reset asserted mid-handshake abandons the request; memory must tolerate a dropped req.
- State encoding is 2-bit: S_BOOT=0, S_FETCH=1, S_STALL=2. Value 3 is illegal and recovers to S_FETCH with out_valid<=0.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W constants.
  - the fetch state enum.
  - a NOP encoding constant (16'h0000) for use by the bubble-aware ID stage.
- Natural sub-module: pc_reg. It takes load-target, increment and hold controls and is reused by later PC-related work.
- The FSM and output registers stay in fetch_unit.

Test Plan:
- Reset release, ready tied 1, memory returns 16'h0100+addr -> req rises 1 cycle after release; IF/ID sees (0x0100,0),(0x0101,1),(0x0102,2) on consecutive edges with out_valid=1.
- Ready low 2 cycles while out_mem_addr=3 -> out_valid=0 for 2 cycles, pc stays 3; then (0x0103,3) valid.
- inp_stall high 3 cycles while holding (0x0104,4) -> req=0 and outputs stable throughout; one bubble follows, then (0x0105,5).
- inp_branch_taken with target 0x0040, coincident with ready at addr 6 -> data discarded, out_valid=0; next request addr=0x0040, then (0x0140,0x0040).
- RESET_PC=16'hFFFF -> fetches FFFF then 0000 (wrap), out_address follows.
- inp_rst_n pulsed low between edges during a wait state -> out_valid=0 and out_mem_req=0 asynchronously; after release, fetch restarts at RESET_PC via S_BOOT.

Source files
------------

// File: rtl/cpu_pkg.sv
// =============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the 16-bit RISC pipeline.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cpu_pkg;

    // Datapath widths
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    // All-zero instruction word, used by the ID stage when it meets a bubble
    localparam logic [15:0] NOP = 16'h0000;

    // Fetch FSM states; encoding 2'd3 is illegal and recovers to S_FETCH
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/pc_reg.sv
// =============================================================================
// Module      : pc_reg
// Description : Program counter register with load / increment / hold
//               controls. Load has priority over increment; the counter
//               wraps modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pc_reg #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC selection: redirect beats increment, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC storage with asynchronous reset to the boot address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : pc_reg

`default_nettype wire

// File: rtl/fetch_unit.sv
// =============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Holds the PC, issues word reads over
//               a req/ready handshake and drives the IF/ID register
//               (instruction, address, valid). Honours stall and branch
//               redirect; redirect wins over stall, stall over the handshake.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               inp_clk,
    input  logic               inp_rst_n,
    output logic               out_mem_req,
    output logic [ADDR_W-1:0]  out_mem_addr,
    input  logic               inp_mem_ready,
    input  logic [INSTR_W-1:0] inp_mem_data,
    input  logic               inp_stall,
    input  logic               inp_branch_taken,
    input  logic [ADDR_W-1:0]  inp_branch_target,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [ADDR_W-1:0]  out_address,
    output logic               out_valid
);
    import cpu_pkg::*;

    fetch_state_e       state_q;
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  addr_q;

    logic [ADDR_W-1:0]  pc;
    logic               mem_req;
    logic               pc_inc;

    // Request only in S_FETCH, and never while redirecting or while IF/ID is
    // refusing a valid instruction. Decoded from state_q so reset drops it
    // immediately.
    always_comb begin
        mem_req = (state_q == S_FETCH) && !inp_branch_taken &&
                  !(inp_stall && valid_q);
    end

    // A completed handshake advances the PC (branch already excluded via req)
    assign pc_inc = mem_req && inp_mem_ready;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i    (inp_clk),
        .rst_ni   (inp_rst_n),
        .load_i   (inp_branch_taken),
        .target_i (inp_branch_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    // Fetch FSM and IF/ID output registers
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_q <= S_BOOT;
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (inp_branch_taken) begin
                        // Any data returned this cycle belongs to the old path
                        valid_q <= 1'b0;
                    end else if (inp_stall && valid_q) begin
                        state_q <= S_STALL;
                    end else if (inp_mem_ready) begin
                        instr_q <= inp_mem_data;
                        addr_q  <= pc;
                        valid_q <= 1'b1;
                        state_q <= inp_stall ? S_STALL : S_FETCH;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                S_STALL: begin
                    if (inp_branch_taken) begin
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end else if (!inp_stall) begin
                        // Held instruction is consumed at this edge; a
                        // single bubble follows
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_mem_req     = mem_req;
    assign out_mem_addr    = pc;
    assign out_instruction = instr_q;
    assign out_address     = addr_q;
    assign out_valid       = valid_q;

endmodule : fetch_unit

`default_nettype wire
